// File: rtl/morse_pkg.sv
// Shared types and constants for the Morse transmit path.
// FSM states, code limits, unit lengths and the ROM entry bundle.
package morse_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MARK = 3'd1,
    S_EGAP = 3'd2,
    S_CGAP = 3'd3,
    S_WGAP = 3'd4,
    S_DONE = 3'd5
  } state_t;

  localparam logic [5:0] CODE_SPACE = 6'd36;
  localparam logic [5:0] CODE_MAX   = 6'd36;

  localparam logic [2:0] DOT_U  = 3'd1;
  localparam logic [2:0] DASH_U = 3'd3;
  localparam logic [2:0] EGAP_U = 3'd1;
  localparam logic [2:0] CGAP_U = 3'd3;
  localparam logic [2:0] WGAP_U = 3'd7;

  // pat is MSB-first: pat[4] is the element
  // about to be sent, 1 = dash, 0 = dot.
  typedef struct packed {
    logic       valid;
    logic [2:0] len;
    logic [4:0] pat;
  } rom_t;

  function automatic rom_t rom_entry(
    input logic [2:0] len,
    input logic [4:0] pat
  );
    rom_t e;
    e.valid = 1'b1;
    e.len   = len;
    e.pat   = pat;
    return e;
  endfunction

  function automatic logic [2:0] elem_units(
    input logic dash
  );
    return dash ? DASH_U : DOT_U;
  endfunction

endpackage

// File: rtl/morse_rom.sv
// Character code to Morse pattern lookup (combinational).
// Ports: char_code[5:0] in; entry {valid, len[2:0], pat[4:0]} out.
module morse_rom
  import morse_pkg::*;
(
  input  logic [5:0] char_code,
  output rom_t       entry
);

  always_comb begin
    entry = '0;
    unique case (char_code)
      6'd0:  entry = rom_entry(3'd2, 5'b01000);
      6'd1:  entry = rom_entry(3'd4, 5'b10000);
      6'd2:  entry = rom_entry(3'd4, 5'b10100);
      6'd3:  entry = rom_entry(3'd3, 5'b10000);
      6'd4:  entry = rom_entry(3'd1, 5'b00000);
      6'd5:  entry = rom_entry(3'd4, 5'b00100);
      6'd6:  entry = rom_entry(3'd3, 5'b11000);
      6'd7:  entry = rom_entry(3'd4, 5'b00000);
      6'd8:  entry = rom_entry(3'd2, 5'b00000);
      6'd9:  entry = rom_entry(3'd4, 5'b01110);
      6'd10: entry = rom_entry(3'd3, 5'b10100);
      6'd11: entry = rom_entry(3'd4, 5'b01000);
      6'd12: entry = rom_entry(3'd2, 5'b11000);
      6'd13: entry = rom_entry(3'd2, 5'b10000);
      6'd14: entry = rom_entry(3'd3, 5'b11100);
      6'd15: entry = rom_entry(3'd4, 5'b01100);
      6'd16: entry = rom_entry(3'd4, 5'b11010);
      6'd17: entry = rom_entry(3'd3, 5'b01000);
      6'd18: entry = rom_entry(3'd3, 5'b00000);
      6'd19: entry = rom_entry(3'd1, 5'b10000);
      6'd20: entry = rom_entry(3'd3, 5'b00100);
      6'd21: entry = rom_entry(3'd4, 5'b00010);
      6'd22: entry = rom_entry(3'd3, 5'b01100);
      6'd23: entry = rom_entry(3'd4, 5'b10010);
      6'd24: entry = rom_entry(3'd4, 5'b10110);
      6'd25: entry = rom_entry(3'd4, 5'b11000);
      6'd26: entry = rom_entry(3'd5, 5'b11111);
      6'd27: entry = rom_entry(3'd5, 5'b01111);
      6'd28: entry = rom_entry(3'd5, 5'b00111);
      6'd29: entry = rom_entry(3'd5, 5'b00011);
      6'd30: entry = rom_entry(3'd5, 5'b00001);
      6'd31: entry = rom_entry(3'd5, 5'b00000);
      6'd32: entry = rom_entry(3'd5, 5'b10000);
      6'd33: entry = rom_entry(3'd5, 5'b11000);
      6'd34: entry = rom_entry(3'd5, 5'b11100);
      6'd35: entry = rom_entry(3'd5, 5'b11110);
      // word space: valid, but no marks
      6'd36: entry = rom_entry(3'd0, 5'b00000);
      default: entry = '0;
    endcase
  end

endmodule

// File: rtl/morse_encoder.sv
// Morse transmitter: plays one character as timed keying on tone_out.
// Ports: clk, rst(n, sync), en, start, char_code[5:0]; tone_out, busy, done, err.
module morse_encoder
  import morse_pkg::*;
#(
  parameter int UNIT_CYCLES = 10_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       start,
  input  logic [5:0] char_code,
  output logic       tone_out,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int CW =
    (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
  localparam logic [CW-1:0] CYC_LAST =
    CW'(UNIT_CYCLES - 1);

  rom_t rom;

  morse_rom u_rom (
    .char_code (char_code),
    .entry     (rom)
  );

  state_t        state, state_n;
  logic [CW-1:0] cyc_cnt, cyc_n;
  logic [2:0]    unit_cnt, unit_n;
  logic [2:0]    len_cnt, len_n;
  logic [4:0]    pat, pat_n;
  logic          err_n;
  logic          tick;
  logic          last_unit;

  assign tick      = (cyc_cnt == CYC_LAST);
  assign last_unit = tick && (unit_cnt == 3'd1);

  always_comb begin
    state_n = state;
    cyc_n   = tick ? '0 : cyc_cnt + CW'(1);
    unit_n  = tick ? unit_cnt - 3'd1 : unit_cnt;
    len_n   = len_cnt;
    pat_n   = pat;
    err_n   = 1'b0;
    unique case (state)
      S_IDLE, S_DONE: begin
        cyc_n  = '0;
        unit_n = '0;
        state_n = S_IDLE;
        if (start) begin
          if (!rom.valid) begin
            err_n = 1'b1;
          end else if (char_code == CODE_SPACE) begin
            state_n = S_WGAP;
            unit_n  = WGAP_U;
          end else begin
            state_n = S_MARK;
            len_n   = rom.len;
            pat_n   = rom.pat;
            unit_n  = elem_units(rom.pat[4]);
          end
        end
      end
      S_MARK: begin
        if (last_unit) begin
          if (len_cnt > 3'd1) begin
            state_n = S_EGAP;
            unit_n  = EGAP_U;
            pat_n   = {pat[3:0], 1'b0};
            len_n   = len_cnt - 3'd1;
          end else begin
            state_n = S_CGAP;
            unit_n  = CGAP_U;
          end
        end
      end
      S_EGAP: begin
        if (last_unit) begin
          state_n = S_MARK;
          unit_n  = elem_units(pat[4]);
        end
      end
      S_CGAP, S_WGAP: begin
        if (last_unit) state_n = S_DONE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= S_IDLE;
      cyc_cnt  <= '0;
      unit_cnt <= '0;
      len_cnt  <= '0;
      pat      <= '0;
      tone_out <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else if (en) begin
      state    <= state_n;
      cyc_cnt  <= cyc_n;
      unit_cnt <= unit_n;
      len_cnt  <= len_n;
      pat      <= pat_n;
      tone_out <= (state_n == S_MARK);
      busy     <= (state_n == S_MARK)
               || (state_n == S_EGAP)
               || (state_n == S_CGAP)
               || (state_n == S_WGAP);
      done     <= (state_n == S_DONE);
      err      <= err_n;
    end
  end

endmodule

// File: tb/tb_morse_encoder.sv
// Self-checking bench for morse_encoder (UNIT_CYCLES=4).
// Directed literal timings plus randomized traffic against a queue model.
module tb_morse_encoder;

  localparam int U = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b1;
  logic       start = 1'b0;
  logic [5:0] char_code = '0;
  logic       tone_out, busy, done, err;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  morse_encoder #(.UNIT_CYCLES(U)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .start     (start),
    .char_code (char_code),
    .tone_out  (tone_out),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  string tbl [36] = '{
    ".-", "-...", "-.-.", "-..", ".", "..-.", "--.",
    "....", "..", ".---", "-.-", ".-..", "--", "-.",
    "---", ".--.", "--.-", ".-.", "...", "-", "..-",
    "...-", ".--", "-..-", "-.--", "--..",
    "-----", ".----", "..---", "...--", "....-",
    ".....", "-....", "--...", "---..", "----."
  };

  // {tone, busy, done, err}
  logic [3:0] q [$];
  logic [3:0] exp_o;

  function automatic void push_n(int n, logic [3:0] v);
    for (int k = 0; k < n; k++) q.push_back(v);
  endfunction

  function automatic void push_char(int c);
    string s;
    if (c == 36) begin
      push_n(7 * U, 4'b0100);
    end else begin
      s = tbl[c];
      for (int i = 0; i < s.len(); i++) begin
        push_n((s[i] == "-") ? 3 * U : U, 4'b1100);
        if (i < s.len() - 1) push_n(U, 4'b0100);
      end
      push_n(3 * U, 4'b0100);
    end
    q.push_back(4'b0010);
  endfunction

  always @(posedge clk) begin
    logic [3:0] nx;
    if (!rst) begin
      q.delete();
      exp_o <= '0;
    end else if (en) begin
      nx = '0;
      if (q.size() == 0 && start) begin
        if (char_code <= 6'd36) push_char(int'(char_code));
        else nx[0] = 1'b1;
      end
      if (q.size() > 0) nx = q.pop_front();
      exp_o <= nx;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      tests++;
      if ({tone_out, busy, done, err} !== exp_o) begin
        fails++;
        $display("FAIL cycle_cmp t=%0t got=%b want=%b",
                 $time, {tone_out, busy, done, err}, exp_o);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic check(string nm, int got, int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s got=%0d want=%0d", nm, got, want);
    end
  endtask

  // start at cycle 0, observe cycles 1.. until done
  task automatic send_timed(string nm, int code,
                            int want_done, int want_tone);
    int n;
    int tn;
    bit mdone;
    n = 0;
    tn = 0;
    mdone = 0;
    start = 1'b1;
    char_code = 6'(code);
    do begin
      @(negedge clk);
      start = 1'b0;
      n++;
      if (tone_out) tn++;
      mdone = exp_o[1];
    end while (!done && n < 300);
    check({nm, "_done_cycle"}, n, want_done);
    check({nm, "_tone_cycles"}, tn, want_tone);
    check({nm, "_model_done"}, int'(mdone), 1);
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int tn;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("reset_outputs",
          int'({tone_out, busy, done, err}), 0);
    rst = 1'b1;
    @(negedge clk);

    send_timed("E", 4, 17, 4);
    send_timed("A", 0, 33, 16);
    send_timed("zero", 26, 89, 60);
    send_timed("space", 36, 29, 0);

    // invalid code while idle
    start = 1'b1;
    char_code = 6'd40;
    @(negedge clk);
    start = 1'b0;
    check("invalid_err", int'(err), 1);
    check("invalid_busy", int'(busy), 0);
    @(negedge clk);
    check("invalid_err_pulse", int'(err), 0);

    // 'T' with en low for cycles 3..10, extra start at 6
    n = 0;
    tn = 0;
    start = 1'b1;
    char_code = 6'd19;
    do begin
      @(negedge clk);
      n++;
      start = (n == 6);
      char_code = (n == 6) ? 6'd4 : 6'd19;
      en = !(n >= 3 && n <= 10);
      if (tone_out) tn++;
    end while (!done && n < 300);
    en = 1'b1;
    start = 1'b0;
    check("T_stall_done_cycle", n, 33);
    check("T_stall_tone_cycles", tn, 20);
    @(negedge clk);
    check("T_no_second_char", int'(busy), 0);

    // reset mid-'A', then 'E' at cycle 8
    n = 0;
    tn = 0;
    start = 1'b1;
    char_code = 6'd0;
    do begin
      @(negedge clk);
      n++;
      start = (n == 8);
      char_code = (n == 8) ? 6'd4 : 6'd0;
      rst = (n != 6);
      if (n == 7)
        check("rst_abort_outputs",
              int'({tone_out, busy, done, err}), 0);
      if (n < 25 && done) tn++;
    end while (!(n > 8 && done) && n < 300);
    start = 1'b0;
    check("rst_then_E_done", n, 25);
    check("rst_no_stray_done", tn, 0);

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      en = ($urandom_range(7) != 0);
      start = ($urandom_range(5) == 0);
      char_code = ($urandom_range(3) == 0)
                ? 6'($urandom_range(63))
                : 6'($urandom_range(36));
      rst = ($urandom_range(599) != 0);
    end
    rst = 1'b1;
    en = 1'b1;
    start = 1'b0;
    repeat (120) @(negedge clk);
    check("final_idle", int'(busy), 0);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
